nx_msg_encoder: RTL and testbench

Host-side message encoder for the Nexus mesh, the transmitting counterpart of the per-node message decoder. It accepts host load requests (instruction load, I/O mapping, signal state), buffers them in a small FIFO and serialises each into a single stream word addressed to a target node. It also expands broadcast requests into one word per node, walking the grid row-major. The single outbound stream drives the north inbound port of node (0,0) with valid/ready flow control.

---
 rtl/nx_msg_encoder_if.sv | 50 +++++
 rtl/nx_msg_encoder.sv | 187 ++++++++++++++++++
 tb/tb_nx_msg_encoder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nx_msg_encoder_if.sv
// Host request bus and outbound stream bundle for the Nexus message encoder.
// The master modport is the encoder's view; slave is the host/downstream view.
interface nx_msg_encoder_if #(
    parameter int STREAM_WIDTH   = 32,
    parameter int ADDR_ROW_WIDTH = 4,
    parameter int ADDR_COL_WIDTH = 4,
    parameter int COMMAND_WIDTH  = 2
);
    localparam int PAYLOAD_WIDTH = STREAM_WIDTH - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - COMMAND_WIDTH;

    // Host request side
    logic [COMMAND_WIDTH-1:0]  req_cmd_i;
    logic [ADDR_ROW_WIDTH-1:0] req_row_i;
    logic [ADDR_COL_WIDTH-1:0] req_col_i;
    logic [PAYLOAD_WIDTH-1:0]  req_payload_i;
    logic                      req_bcast_i;
    logic                      req_valid_i;
    logic                      req_ready_o;

    // Outbound stream side (feeds the north port of node (0,0))
    logic [STREAM_WIDTH-1:0]   msg_data_o;
    logic                      msg_valid_o;
    logic                      msg_ready_i;

    modport master (
        input  req_cmd_i,
        input  req_row_i,
        input  req_col_i,
        input  req_payload_i,
        input  req_bcast_i,
        input  req_valid_i,
        output req_ready_o,
        output msg_data_o,
        output msg_valid_o,
        input  msg_ready_i
    );

    modport slave (
        output req_cmd_i,
        output req_row_i,
        output req_col_i,
        output req_payload_i,
        output req_bcast_i,
        output req_valid_i,
        input  req_ready_o,
        input  msg_data_o,
        input  msg_valid_o,
        output msg_ready_i
    );
endinterface

// File: rtl/nx_msg_encoder.sv
// Nexus mesh host-side message encoder: buffers host requests in a small FIFO,
// serialises each into one addressed stream word, and expands broadcasts into
// one word per node in row-major order.
module nx_msg_encoder #(
    parameter int STREAM_WIDTH   = 32,
    parameter int ADDR_ROW_WIDTH = 4,
    parameter int ADDR_COL_WIDTH = 4,
    parameter int COMMAND_WIDTH  = 2,
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    nx_msg_encoder_if.master     bus,
    output logic                 idle_o,
    output logic [31:0]          sent_count_o
);
    localparam int PAYLOAD_WIDTH = STREAM_WIDTH - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - COMMAND_WIDTH;
    localparam int ENTRY_WIDTH   = COMMAND_WIDTH + ADDR_ROW_WIDTH + ADDR_COL_WIDTH + PAYLOAD_WIDTH + 1;
    localparam int PTR_W         = $clog2(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BCAST = 1'b1;

    localparam logic [ADDR_ROW_WIDTH-1:0] LAST_ROW  = ADDR_ROW_WIDTH'(ROWS - 1);
    localparam logic [ADDR_COL_WIDTH-1:0] LAST_COL  = ADDR_COL_WIDTH'(COLS - 1);
    // Position following (0,0) in row-major order; single-column grids step down a row.
    localparam logic [ADDR_ROW_WIDTH-1:0] FIRST_ROW = ADDR_ROW_WIDTH'((COLS == 1) ? 1 : 0);
    localparam logic [ADDR_COL_WIDTH-1:0] FIRST_COL = ADDR_COL_WIDTH'((COLS == 1) ? 0 : 1);
    localparam bit                        SINGLE_NODE = (ROWS * COLS == 1);

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_WIDTH-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]         r_wr_ptr;
    logic [PTR_W:0]         r_rd_ptr;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic [ENTRY_WIDTH-1:0] w_push_entry;
    logic [ENTRY_WIDTH-1:0] w_head;

    logic [COMMAND_WIDTH-1:0]  w_head_cmd;
    logic [ADDR_ROW_WIDTH-1:0] w_head_row;
    logic [ADDR_COL_WIDTH-1:0] w_head_col;
    logic [PAYLOAD_WIDTH-1:0]  w_head_payload;
    logic                      w_head_bcast;

    // Full/empty come from registered pointers only, so a pop cannot open a slot
    // for a push in the same cycle.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    assign bus.req_ready_o = !w_full && !rst_i;
    assign w_push          = bus.req_valid_i && bus.req_ready_o;
    assign w_push_entry    = {bus.req_cmd_i, bus.req_row_i, bus.req_col_i,
                              bus.req_payload_i, bus.req_bcast_i};

    assign w_head = r_fifo_mem[r_rd_ptr[PTR_W-1:0]];
    assign {w_head_cmd, w_head_row, w_head_col, w_head_payload, w_head_bcast} = w_head;

    // Storage array: written on push, no reset needed since pointers guard reads.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr[PTR_W-1:0]] <= w_push_entry;
        end
    end

    // FIFO pointers; reset flushes any queued requests.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage and broadcast FSM
    // ------------------------------------------------------------------
    logic [0:0]                r_state;
    logic [STREAM_WIDTH-1:0]   r_msg_data;
    logic                      r_msg_valid;
    logic [ADDR_ROW_WIDTH-1:0] r_bc_row;
    logic [ADDR_COL_WIDTH-1:0] r_bc_col;
    logic [COMMAND_WIDTH-1:0]  r_bc_cmd;
    logic [PAYLOAD_WIDTH-1:0]  r_bc_payload;
    logic [31:0]               r_sent_count;

    logic                      w_out_free;
    logic                      w_bc_last;
    logic [ADDR_ROW_WIDTH-1:0] w_bc_row_next;
    logic [ADDR_COL_WIDTH-1:0] w_bc_col_next;

    assign w_out_free = !r_msg_valid || bus.msg_ready_i;
    assign w_pop      = (r_state == ST_IDLE) && !w_empty && w_out_free;
    assign w_bc_last  = (r_bc_row == LAST_ROW) && (r_bc_col == LAST_COL);

    // Row-major step of the broadcast cursor: advance column, wrap into next row.
    always_comb begin
        w_bc_row_next = r_bc_row;
        w_bc_col_next = r_bc_col + ADDR_COL_WIDTH'(1);
        if (r_bc_col == LAST_COL) begin
            w_bc_col_next = '0;
            w_bc_row_next = r_bc_row + ADDR_ROW_WIDTH'(1);
        end
    end

    // FSM and output register: load a new word whenever the stage is free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_msg_data   <= '0;
            r_msg_valid  <= 1'b0;
            r_bc_row     <= '0;
            r_bc_col     <= '0;
            r_bc_cmd     <= '0;
            r_bc_payload <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_msg_valid <= 1'b1;
                        if (w_head_bcast) begin
                            // First broadcast word always targets (0,0).
                            r_msg_data   <= {{ADDR_ROW_WIDTH{1'b0}}, {ADDR_COL_WIDTH{1'b0}},
                                             w_head_cmd, w_head_payload};
                            r_bc_cmd     <= w_head_cmd;
                            r_bc_payload <= w_head_payload;
                            if (!SINGLE_NODE) begin
                                r_bc_row <= FIRST_ROW;
                                r_bc_col <= FIRST_COL;
                                r_state  <= ST_BCAST;
                            end
                        end else begin
                            r_msg_data <= {w_head_row, w_head_col, w_head_cmd, w_head_payload};
                        end
                    end else if (w_out_free) begin
                        r_msg_valid <= 1'b0;
                    end
                end
                ST_BCAST: begin
                    if (w_out_free) begin
                        r_msg_valid <= 1'b1;
                        r_msg_data  <= {r_bc_row, r_bc_col, r_bc_cmd, r_bc_payload};
                        if (w_bc_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_bc_row <= w_bc_row_next;
                            r_bc_col <= w_bc_col_next;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_msg_valid <= 1'b0;
                end
            endcase
        end
    end

    // Count completed outbound transfers; a word in flight at reset is not counted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sent_count <= '0;
        end else if (r_msg_valid && bus.msg_ready_i) begin
            r_sent_count <= r_sent_count + 32'd1;
        end
    end

    assign bus.msg_data_o  = r_msg_data;
    assign bus.msg_valid_o = r_msg_valid;
    assign sent_count_o    = r_sent_count;
    assign idle_o          = w_empty && (r_state == ST_IDLE) && !r_msg_valid;

endmodule

// File: tb/tb_nx_msg_encoder.sv
// Self-checking bench for nx_msg_encoder: directed scenarios plus randomized
// traffic scored against a queue-based model of the expected word stream.
module tb_nx_msg_encoder;
    localparam int SW = 32, RW = 4, CW = 4, MW = 2;
    localparam int ROWS = 4, COLS = 4, DEPTH = 4;
    localparam int PW = SW - RW - CW - MW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        idle;
    logic [31:0] sent_count;

    always #5 clk = ~clk;

    nx_msg_encoder_if #(.STREAM_WIDTH(SW), .ADDR_ROW_WIDTH(RW),
                        .ADDR_COL_WIDTH(CW), .COMMAND_WIDTH(MW)) bus ();

    nx_msg_encoder #(
        .STREAM_WIDTH(SW), .ADDR_ROW_WIDTH(RW), .ADDR_COL_WIDTH(CW),
        .COMMAND_WIDTH(MW), .ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .idle_o      (idle),
        .sent_count_o(sent_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] word(input logic [MW-1:0] cmd, input logic [RW-1:0] row,
                                           input logic [CW-1:0] col, input logic [PW-1:0] pl);
        return {row, col, cmd, pl};
    endfunction

    // ---------------- model / monitor ----------------
    logic [SW-1:0] exp_q[$];
    logic [31:0]   model_sent = 0;
    int            cycle = 0;
    int            beats_seen = 0;
    int            hs_cyc[$];
    logic [SW-1:0] last_beat;
    bit            prev_stall = 0;
    logic [SW-1:0] prev_data;

    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            exp_q.delete();
            model_sent = 0;
            prev_stall = 0;
            check("ready_in_reset", bus.req_ready_o, 0);
        end else begin
            check("sent_count", sent_count, model_sent);
            check("idle", idle, exp_q.size() == 0);
            if (exp_q.size() == 0) check("valid_without_pending", bus.msg_valid_o, 0);
            if (prev_stall) begin
                check("stall_valid", bus.msg_valid_o, 1);
                check("stall_data", bus.msg_data_o, prev_data);
            end
            if (bus.msg_valid_o && bus.msg_ready_i) begin
                if (exp_q.size() != 0) begin
                    check("beat_data", bus.msg_data_o, exp_q.pop_front());
                end
                model_sent++;
                beats_seen++;
                hs_cyc.push_back(cycle);
                last_beat = bus.msg_data_o;
            end
            prev_stall = bus.msg_valid_o && !bus.msg_ready_i;
            prev_data  = bus.msg_data_o;
            if (bus.req_valid_i && bus.req_ready_o) begin
                if (bus.req_bcast_i) begin
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            exp_q.push_back(word(bus.req_cmd_i, RW'(r), CW'(c), bus.req_payload_i));
                end else begin
                    exp_q.push_back(word(bus.req_cmd_i, bus.req_row_i, bus.req_col_i, bus.req_payload_i));
                end
            end
        end
    end

    // ---------------- downstream ready driver ----------------
    int ready_mode = 1; // 0 low, 1 high, 2 random
    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       bus.msg_ready_i = 1'b0;
            1:       bus.msg_ready_i = 1'b1;
            default: bus.msg_ready_i = ($urandom_range(3) != 0);
        endcase
    end

    // ---------------- host driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [MW-1:0] cmd, input logic [RW-1:0] row, input logic [CW-1:0] col,
                        input logic [PW-1:0] pl, input bit bc, input int max_wait, output bit ok);
        bus.req_cmd_i     = cmd;
        bus.req_row_i     = row;
        bus.req_col_i     = col;
        bus.req_payload_i = pl;
        bus.req_bcast_i   = bc;
        bus.req_valid_i   = 1'b1;
        ok = 0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clk);
            ok = bus.req_ready_o;
            tick();
        end
        bus.req_valid_i = 1'b0;
    endtask

    task automatic send_must(input logic [MW-1:0] cmd, input logic [RW-1:0] row, input logic [CW-1:0] col,
                             input logic [PW-1:0] pl, input bit bc);
        bit ok;
        send(cmd, row, col, pl, bc, 500, ok);
        if (!ok) begin
            tests++; fails++;
            $display("FAIL req_accept_timeout: got not-accepted expected accepted");
        end
    endtask

    task automatic drain(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (exp_q.size() == 0 && idle) break;
            tick();
        end
        if (i == bound) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    int exp_total;

    initial begin
        bit ok;
        int accepted;
        int base;
        bus.req_cmd_i = '0; bus.req_row_i = '0; bus.req_col_i = '0;
        bus.req_payload_i = '0; bus.req_bcast_i = 1'b0; bus.req_valid_i = 1'b0;
        bus.msg_ready_i = 1'b1;

        // Reset and reset values
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", bus.req_ready_o, 1);
        check("rst_msg_valid", bus.msg_valid_o, 0);
        check("rst_msg_data", bus.msg_data_o, 0);
        check("rst_idle", idle, 1);
        check("rst_sent_count", sent_count, 0);
        tick();

        // Model pinned against hand-computed words
        check("model_word_single", word(2'd0, 4'd2, 4'd3, 22'h12345), 32'h2301_2345);
        check("model_word_bcast_00", word(2'd2, 4'd0, 4'd0, 22'h1), 32'h0080_0001);

        // Single send with latency N+2
        send_must(2'd0, 4'd2, 4'd3, 22'h12345, 1'b0);
        check("single_n1_valid", bus.msg_valid_o, 0);
        tick();
        check("single_n2_valid", bus.msg_valid_o, 1);
        check("single_n2_data", bus.msg_data_o, 32'h2301_2345);
        drain(100);
        tick();
        check("single_count", sent_count, 1);
        check("single_idle", idle, 1);

        // Broadcast expansion
        hs_cyc.delete();
        send_must(2'd2, 4'd0, 4'd0, 22'h1, 1'b1);
        tick();
        check("bcast_first_data", bus.msg_data_o, 32'h0080_0001);
        drain(200);
        tick();
        check("bcast_beats", hs_cyc.size(), 16);
        if (hs_cyc.size() == 16) check("bcast_back_to_back", hs_cyc[15] - hs_cyc[0], 15);
        check("bcast_last_data", last_beat, 32'h3380_0001);
        check("bcast_count", sent_count, 17);

        // Backpressure: only FIFO_DEPTH+1 requests fit
        ready_mode = 0;
        tick(); tick();
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            send(2'(i), 4'(i % ROWS), 4'((i + 1) % COLS), PW'($urandom), 1'b0, 3, ok);
            if (ok) accepted++;
        end
        check("bp_accepted", accepted, DEPTH + 1);
        check("bp_req_ready", bus.req_ready_o, 0);
        repeat (3) tick();
        hs_cyc.delete();
        ready_mode = 1;
        drain(200);
        check("bp_beats", hs_cyc.size(), 5);

        // Mixed single/broadcast/single without gaps
        tick();
        hs_cyc.delete();
        send_must(2'd1, 4'd1, 4'd2, 22'h2AAAA, 1'b0);
        send_must(2'd3, 4'd0, 4'd0, 22'h15555, 1'b1);
        send_must(2'd0, 4'd3, 4'd1, 22'h3FFFFF, 1'b0);
        drain(300);
        check("mixed_beats", hs_cyc.size(), 18);
        if (hs_cyc.size() == 18) check("mixed_no_gap", hs_cyc[17] - hs_cyc[0], 17);

        // Reset in the middle of a broadcast
        tick();
        base = beats_seen;
        send_must(2'd2, 4'd0, 4'd0, 22'h7, 1'b1);
        for (int i = 0; i < 100 && beats_seen < base + 5; i++) tick();
        check("rst_mid_reached5", beats_seen >= base + 5, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", bus.msg_valid_o, 0);
        check("rst_mid_idle", idle, 1);
        check("rst_mid_count", sent_count, 0);
        base = beats_seen;
        repeat (30) tick();
        check("rst_mid_no_beats", beats_seen - base, 0);

        // Randomized traffic with random downstream ready
        ready_mode = 2;
        exp_total = 0;
        for (int n = 0; n < 1000; n++) begin
            bit bc;
            bc = ($urandom_range(19) == 0);
            send_must(MW'($urandom), RW'($urandom_range(ROWS - 1)), CW'($urandom_range(COLS - 1)),
                      PW'($urandom), bc);
            exp_total += bc ? ROWS * COLS : 1;
            repeat ($urandom_range(2)) tick();
        end
        drain(20000);
        tick();
        check("rand_sent_total", sent_count, exp_total);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
